// File: rtl/led_matrix_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// led_matrix_scan_driver : row-scanned LED matrix driver with tear-free frame
// swap; define SCAN_BLANK_EN for all-dark gaps between rows.    Rev 1.0
// ============================================================================
module led_matrix_scan_driver #(
  parameter int ROWS  = 7,
  parameter int COLS  = 5,
  parameter int DWELL = 1000,
  parameter int BLANK = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLS-1:0] in_data,
  input  logic            in_sof,
  output logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col,
  output logic            frame_done
);

  localparam int c_RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int c_CMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int c_CW   = $clog2(c_CMAX + 1);

  localparam logic [c_RW-1:0] c_ROW_LAST   = c_RW'(ROWS - 1);
  localparam logic [c_RW-1:0] c_ROW_ONE    = c_RW'(1);
  localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
  localparam logic [c_CW-1:0] c_DWELL_LAST = c_CW'(DWELL - 1);

  localparam logic [0:0] c_ST_DRIVE = 1'b1;
`ifdef SCAN_BLANK_EN
  localparam logic [0:0]      c_ST_BLANK   = 1'b0;
  localparam logic [c_CW-1:0] c_BLANK_LAST = c_CW'(BLANK - 1);
  localparam logic [0:0]      c_ST_RST     = c_ST_BLANK;
  localparam logic [ROWS-1:0] c_ROW_N_RST  = '1;
`else
  localparam logic [0:0]      c_ST_RST     = c_ST_DRIVE;
  localparam logic [ROWS-1:0] c_ROW_N_RST  = ~ROWS'(1);
`endif

  logic [0:0]                 state_q, state_d;
  logic [c_RW-1:0]            row_q, row_d;
  logic [c_CW-1:0]            cnt_q, cnt_d;
  logic [c_RW-1:0]            wptr_q, wptr_d;
  logic [ROWS-1:0][COLS-1:0]  back_q, back_d;
  logic [ROWS-1:0][COLS-1:0]  front_q, front_d;
  logic                       pending_q, pending_d;
  logic                       frame_done_q;
  logic [ROWS-1:0]            row_n_q, row_n_d;
  logic [COLS-1:0]            col_q, col_d;

  logic                       w_accept;
  logic                       w_drive_end;
  logic                       w_swap;
  logic [c_RW-1:0]            w_widx;

  assign w_accept    = in_valid & ~pending_q;
  assign w_widx      = in_sof ? '0 : wptr_q;
  assign w_drive_end = (state_q == c_ST_DRIVE) && (cnt_q == c_DWELL_LAST);
  // Swap only on the last lit cycle of the bottom row, using pending from before this edge.
  assign w_swap      = w_drive_end && (row_q == c_ROW_LAST) && pending_q;

  // Scan state register; outputs are registered from next-state values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_RST;
      row_q   <= '0;
      cnt_q   <= '0;
      row_n_q <= c_ROW_N_RST;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      row_n_q <= row_n_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q + c_CNT_ONE;
    if (w_drive_end) begin
      cnt_d = '0;
      row_d = (row_q == c_ROW_LAST) ? '0 : row_q + c_ROW_ONE;
`ifdef SCAN_BLANK_EN
      state_d = c_ST_BLANK;
    end else if ((state_q == c_ST_BLANK) && (cnt_q == c_BLANK_LAST)) begin
      cnt_d   = '0;
      state_d = c_ST_DRIVE;
`endif
    end
  end

  always_comb begin
    row_n_d = '1;
    col_d   = '0;
    if (state_d == c_ST_DRIVE) begin
      row_n_d[row_d] = 1'b0;
      col_d          = front_d[row_d];
    end
  end

  // Frame buffers: accept and swap never coincide because both key off pending.
  always_comb begin
    back_d    = back_q;
    front_d   = front_q;
    wptr_d    = wptr_q;
    pending_d = pending_q;
    if (w_swap) begin
      front_d   = back_q;
      pending_d = 1'b0;
    end
    if (w_accept) begin
      back_d[w_widx] = in_data;
      if (w_widx == c_ROW_LAST) begin
        wptr_d    = '0;
        pending_d = 1'b1;
      end else begin
        wptr_d = w_widx + c_ROW_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      back_q       <= '0;
      front_q      <= '0;
      wptr_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      back_q       <= back_d;
      front_q      <= front_d;
      wptr_q       <= wptr_d;
      pending_q    <= pending_d;
      frame_done_q <= w_swap;
    end
  end

  assign in_ready   = ~pending_q;
  assign row_n      = row_n_q;
  assign col        = col_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_matrix_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_led_matrix_scan_driver : scoreboard bench with time-based display model.
// Rev 1.0
// ============================================================================
module tb_led_matrix_scan_driver;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef SCAN_BLANK_EN
  localparam int BLANK_CYC = BLANK;
`else
  localparam int BLANK_CYC = 0;
`endif
  localparam int PER   = DWELL + BLANK_CYC;
  localparam int FRAME = ROWS * PER;

  typedef logic [ROWS-1:0][COLS-1:0] frame_t;
  typedef struct packed {
    logic [ROWS-1:0] row_n;
    logic [COLS-1:0] col;
    logic            rdy;
    logic            fd;
  } exp_t;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_sof   = 1'b0;
  logic [COLS-1:0] in_data  = '0;
  logic            in_ready;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col;
  logic            frame_done;

  led_matrix_scan_driver #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .DWELL (DWELL),
    .BLANK (BLANK)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .row_n      (row_n),
    .col        (col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model: display position is pure arithmetic on cycles since reset.
  int              m_t;
  int              m_wptr;
  logic            m_pending;
  logic            m_fd;
  logic            m_acc;
  logic [COLS-1:0] m_back  [ROWS];
  logic [COLS-1:0] m_front [ROWS];

  function automatic int cur_row();
    return (m_t % FRAME) / PER;
  endfunction

  function automatic bit cur_lit();
    return (m_t % PER) >= BLANK_CYC;
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.row_n = '1;
    e.col   = '0;
    if (cur_lit()) begin
      e.row_n[cur_row()] = 1'b0;
      e.col              = m_front[cur_row()];
    end
    e.rdy = ~m_pending;
    e.fd  = m_fd;
    return e;
  endfunction

  task automatic model_reset();
    m_t = 0; m_wptr = 0; m_pending = 1'b0; m_fd = 1'b0; m_acc = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      m_back[i]  = '0;
      m_front[i] = '0;
    end
  endtask

  task automatic model_step();
    bit acc;
    int idx;
    acc  = in_valid && !m_pending;
    m_fd = ((m_t % FRAME) == FRAME - 1) && m_pending;
    if (m_fd) begin
      m_front   = m_back;
      m_pending = 1'b0;
    end
    if (acc) begin
      idx         = in_sof ? 0 : m_wptr;
      m_back[idx] = in_data;
      if (idx == ROWS - 1) begin
        m_pending = 1'b1;
        m_wptr    = 0;
      end else begin
        m_wptr = idx + 1;
      end
    end
    m_acc = acc;
    m_t   = m_t + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
    exp_q.push_back(expected());
  end

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    exp_t a;
    bit   started;
    started = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        if (started) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty at %0t: got nothing, required one entry", $time);
        end
      end else begin
        e = exp_q.pop_front();
        started = 1'b1;
        a = {row_n, col, in_ready, frame_done};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL cycle_outputs at %0t: row_n=%b col=%b ready=%b fd=%b, required row_n=%b col=%b ready=%b fd=%b",
                   $time, a.row_n, a.col, a.rdy, a.fd, e.row_n, e.col, e.rdy, e.fd);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = COLS'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_beat(input logic [COLS-1:0] d, input logic sof);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!m_acc && n < 4 * FRAME);
    if (!m_acc) begin
      checks++;
      failures++;
      $display("FAIL beat_accept_timeout: waited %0d cycles, required acceptance within %0d", n, 4 * FRAME);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input bit gaps);
    for (int i = 0; i < ROWS; i++) begin
      send_beat(f[i], i == 0);
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < ROWS; i++) f[i] = COLS'($urandom);
    return f;
  endfunction

  initial begin
    frame_t fa;
    int     n;
    exp_t   a;
    exp_t   e;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * FRAME);

    fa[0] = 5'b01110; fa[1] = 5'b01010; fa[2] = 5'b01110; fa[3] = 5'b01010;
    fa[4] = 5'b01010; fa[5] = 5'b00000; fa[6] = 5'b00000;
    send_frame(fa, 1'b0);
    send_frame(rand_frame(), 1'b0);
    idle(3 * FRAME);

    // Restart: three stray beats, then a full frame led by in_sof.
    for (int i = 0; i < 3; i++) send_beat(COLS'($urandom), 1'b0);
    send_beat(5'b11111, 1'b1);
    for (int i = 1; i < ROWS; i++) send_beat(5'b00000, 1'b0);
    idle(2 * FRAME);

    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        send_beat(COLS'($urandom), $urandom_range(0, 9) == 0);
        idle($urandom_range(0, 2));
      end
      send_frame(rand_frame(), 1'b1);
      idle($urandom_range(0, FRAME));
    end
    idle(2 * FRAME);

    // Second frame lands just after a swap, so pending is set while row 3 is lit.
    send_frame(rand_frame(), 1'b0);
    send_frame(rand_frame(), 1'b0);
    n = 0;
    while (!(m_pending && cur_lit() && cur_row() == 3) && n < 6 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (!(m_pending && cur_lit() && cur_row() == 3)) begin
      checks++;
      failures++;
      $display("FAIL wait_drive3_pending: not reached in %0d cycles, required within %0d", n, 6 * FRAME);
    end
    #2 rst_n = 1'b0;
    #1;
    a = {row_n, col, in_ready, frame_done};
    e = expected();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL async_reset_outputs: row_n=%b col=%b ready=%b fd=%b, required row_n=%b col=%b ready=%b fd=%b",
               a.row_n, a.col, a.rdy, a.fd, e.row_n, e.col, e.rdy, e.fd);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * FRAME);
    send_frame(rand_frame(), 1'b1);
    idle(3 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded 1 ms without finishing");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
